// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: zero-fills a lane-masked single-port SRAM after reset, then arbitrates write-priority read/write channels onto its RW port
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   w_valid/w_ready/w_addr/w_mask/w_data : write request channel
//   r_valid/r_ready/r_addr  : read request channel
//   r_resp_valid/r_resp_data: read response pulse and held read data
//   init_done               : zero-fill complete
//   sram_*                  : SRAM RW port (rdata valid the cycle after a read enable)
module sram_rw_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LANES  = 10,
  parameter int LANE_W = 34,
  parameter int DATA_W = LANES * LANE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [LANES-1:0]  w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] hold;
  logic pend, init_wr, w_acc, r_acc;
  // the fill port stays quiet while reset is held so the port is idle out of reset
  assign init_wr = (state == INIT) && !reset;
  assign w_ready = state == RUN;
  assign r_ready = (state == RUN) && !w_valid;
  assign w_acc = w_valid && w_ready;
  assign r_acc = r_valid && r_ready;
  assign sram_en = init_wr || w_acc || r_acc;
  assign sram_wmode = init_wr || w_acc;
  assign sram_addr = init_wr ? cnt : w_acc ? w_addr : r_acc ? r_addr : '0;
  assign sram_wmask = init_wr ? '1 : w_acc ? w_mask : '0;
  assign sram_wdata = w_acc ? w_data : '0;
  assign r_resp_valid = pend;
  // the response cycle shows the macro output directly; the copy held afterwards is immune to later writes
  assign r_resp_data = pend ? sram_rdata : hold;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      init_done <= 1'b0;
      pend <= 1'b0;
      hold <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state <= RUN;
          init_done <= 1'b1;
        end
      end
      pend <= r_acc;
      if (pend) hold <= sram_rdata;
    end
  end
endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb_sram_rw_ctrl: directed self-checking bench for sram_rw_ctrl with a behavioural lane-masked SRAM
module tb_sram_rw_ctrl;
  localparam int DW = 340;
  logic clock = 1'b0, reset = 1'b1;
  logic w_valid = 1'b0, r_valid = 1'b0;
  logic [7:0] w_addr = '0, r_addr = '0;
  logic [9:0] w_mask = '0;
  logic [DW-1:0] w_data = '0;
  logic w_ready, r_ready, r_resp_valid, init_done, sram_en, sram_wmode;
  logic [DW-1:0] r_resp_data, sram_wdata, sram_rdata;
  logic [7:0] sram_addr;
  logic [9:0] sram_wmask;
  logic [DW-1:0] mem [256];
  int checks = 0, errors = 0;

  sram_rw_ctrl dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data), .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // behavioural macro: lane-masked write, one-cycle registered read
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {10{34'h2AAAAAAAA}};
    sram_rdata = '0;
  end
  always @(posedge clock)
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < 10; l++)
          if (sram_wmask[l]) mem[sram_addr][l*34 +: 34] = sram_wdata[l*34 +: 34];
      end else sram_rdata <= mem[sram_addr];
    end

  function automatic logic [DW-1:0] rep(input logic [33:0] v);
    return {10{v}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic init_walk(input bit poke);
    for (int i = 0; i < 256; i++) begin
      w_valid = poke && i < 4;
      r_valid = poke && i < 4;
      w_addr = 8'h55;
      r_addr = 8'h66;
      #1;
      chk("init_en", DW'(sram_en), DW'(1));
      chk("init_wmode", DW'(sram_wmode), DW'(1));
      chk("init_addr", DW'(sram_addr), DW'(i));
      chk("init_wmask", DW'(sram_wmask), DW'(10'h3FF));
      chk("init_wdata", sram_wdata, '0);
      chk("init_wready", DW'(w_ready), DW'(0));
      chk("init_rready", DW'(r_ready), DW'(0));
      chk("init_done_low", DW'(init_done), DW'(0));
      step();
    end
    w_valid = 1'b0;
    r_valid = 1'b0;
    #1;
    chk("init_done_high", DW'(init_done), DW'(1));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [9:0] m, input logic [DW-1:0] d);
    w_valid = 1'b1; w_addr = a; w_mask = m; w_data = d;
    #1;
    chk("wr_ready", DW'(w_ready), DW'(1));
    chk("wr_en", DW'(sram_en), DW'(1));
    chk("wr_wmode", DW'(sram_wmode), DW'(1));
    chk("wr_addr", DW'(sram_addr), DW'(a));
    chk("wr_wmask", DW'(sram_wmask), DW'(m));
    chk("wr_wdata", sram_wdata, d);
    step();
    w_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [DW-1:0] exp);
    r_valid = 1'b1; r_addr = a;
    #1;
    chk("rd_ready", DW'(r_ready), DW'(1));
    chk("rd_en", DW'(sram_en), DW'(1));
    chk("rd_wmode", DW'(sram_wmode), DW'(0));
    chk("rd_addr", DW'(sram_addr), DW'(a));
    step();
    r_valid = 1'b0;
    #1;
    chk("rsp_valid", DW'(r_resp_valid), DW'(1));
    chk("rsp_data", r_resp_data, exp);
    step();
    chk("rsp_pulse_end", DW'(r_resp_valid), DW'(0));
    chk("rsp_hold", r_resp_data, exp);
  endtask

  initial begin
    logic [DW-1:0] mix;
    // reset state
    #2;
    chk("rst_wready", DW'(w_ready), DW'(0));
    chk("rst_rready", DW'(r_ready), DW'(0));
    chk("rst_en", DW'(sram_en), DW'(0));
    chk("rst_rdata", r_resp_data, '0);
    chk("rst_rvalid", DW'(r_resp_valid), DW'(0));
    chk("rst_done", DW'(init_done), DW'(0));
    step(); step();
    reset = 1'b0;
    init_walk(1'b1);
    // idle in RUN
    #1;
    chk("idle_en", DW'(sram_en), DW'(0));
    chk("idle_addr", DW'(sram_addr), DW'(0));
    do_read(8'h00, '0);
    do_read(8'h80, '0);
    do_read(8'hFF, '0);
    // full write then immediate read, then hold across idle
    do_write(8'h12, 10'h3FF, rep(34'h5));
    do_read(8'h12, rep(34'h5));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_rvalid", DW'(r_resp_valid), DW'(0));
      chk("idle_hold", r_resp_data, rep(34'h5));
    end
    // masked write: held data unaffected, lane0 only changes
    do_write(8'h12, 10'h001, rep(34'h3FFFFFFFF));
    #1;
    chk("hold_after_write", r_resp_data, rep(34'h5));
    mix = rep(34'h5);
    mix[33:0] = 34'h3FFFFFFFF;
    do_read(8'h12, mix);
    // write priority over simultaneous read
    r_valid = 1'b1; r_addr = 8'h21;
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1; w_addr = 8'(8'h20 + i); w_mask = 10'h3FF; w_data = rep(34'(7 + i));
      #1;
      chk("pri_rready", DW'(r_ready), DW'(0));
      chk("pri_wmode", DW'(sram_wmode), DW'(1));
      chk("pri_addr", DW'(sram_addr), DW'(8'h20 + i));
      step();
    end
    w_valid = 1'b0;
    #1;
    chk("pri_read_acc", DW'(r_ready), DW'(1));
    chk("pri_read_addr", DW'(sram_addr), DW'(8'h21));
    step();
    r_valid = 1'b0;
    #1;
    chk("pri_rsp_valid", DW'(r_resp_valid), DW'(1));
    chk("pri_rsp_data", r_resp_data, rep(34'h8));
    step();
    // all-zero mask write leaves entry intact
    do_write(8'h22, 10'h000, {DW{1'b1}});
    do_read(8'h22, rep(34'h9));
    // back-to-back reads
    do_write(8'h01, 10'h3FF, rep(34'h1));
    do_write(8'h02, 10'h3FF, rep(34'h2));
    do_write(8'h03, 10'h3FF, rep(34'h3));
    for (int i = 1; i <= 4; i++) begin
      r_valid = i <= 3;
      r_addr = 8'(i);
      #1;
      if (i > 1) begin
        chk("b2b_valid", DW'(r_resp_valid), DW'(1));
        chk("b2b_data", r_resp_data, rep(34'(i - 1)));
      end
      step();
    end
    chk("b2b_end", DW'(r_resp_valid), DW'(0));
    // reset while a response is pending
    r_valid = 1'b1; r_addr = 8'h12;
    step();
    r_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rvalid", DW'(r_resp_valid), DW'(0));
    chk("mid_done", DW'(init_done), DW'(0));
    chk("mid_rdata", r_resp_data, '0);
    chk("mid_en", DW'(sram_en), DW'(0));
    step();
    chk("mid_rvalid2", DW'(r_resp_valid), DW'(0));
    reset = 1'b0;
    init_walk(1'b0);
    do_read(8'h12, '0);
    do_read(8'h21, '0);
    do_read(8'h03, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_rw_ctrl.md
Name: sram_rw_ctrl

Overview:
Initiator-side controller for a single-port, lane-masked SRAM macro (256 x 340b, 10 lanes x 34b, one-cycle registered read). It zero-fills the array after reset. It then arbitrates independent read and write request channels onto the single RW port, with write priority. It returns read data with a valid pulse and holds that data stable until the next read completes.

Parameters:
DEPTH, 256, number of SRAM entries
ADDR_W, 8, address width (log2 DEPTH)
LANES, 10, write-mask lanes
LANE_W, 34, bits per lane
DATA_W, 340, LANES*LANE_W

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
w_valid  in  1  write request valid
w_ready  out  1  write request accepted when w_valid && w_ready
w_addr  in  ADDR_W  write address
w_mask  in  LANES  per-lane write enable
w_data  in  DATA_W  write data
r_valid  in  1  read request valid
r_ready  out  1  read request accepted when r_valid && r_ready
r_addr  in  ADDR_W  read address
r_resp_valid  out  1  one-cycle pulse: r_resp_data carries new read data
r_resp_data  out  DATA_W  read data, held stable between responses
init_done  out  1  high once the zero-fill is complete
sram_en  out  1  SRAM port enable
sram_wmode  out  1  1 = write, 0 = read
sram_addr  out  ADDR_W  SRAM address
sram_wmask  out  LANES  SRAM lane mask
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

Behaviour:
- States: INIT and RUN. Reset (async, any time) forces INIT.
- Reset also clears: init counter = 0, init_done = 0, r_resp_valid = 0, hold register = 0, read-pending flag = 0.
- Reset values of outputs: w_ready = 0, r_ready = 0, sram_en = 0, r_resp_data = 0.
- INIT, per cycle: sram_en = 1, sram_wmode = 1, sram_addr = counter, sram_wmask = all ones, sram_wdata = 0; counter += 1.
- INIT exit: after writing entry DEPTH-1 (DEPTH cycles after reset deassertion), move to RUN and set init_done = 1. The counter does not wrap back into INIT.
- During INIT, w_ready = r_ready = 0 and requests are ignored.
- RUN, write channel: w_ready = 1. An accepted write drives sram_en = 1, sram_wmode = 1, and addr/mask/data straight from the request in the same cycle (combinational pass-through, no added latency).
- RUN, read channel: r_ready = !w_valid, so a write has priority in the same cycle. An accepted read drives sram_en = 1, sram_wmode = 0, sram_addr = r_addr.
- RUN, idle: no accepted request gives sram_en = 0. sram_addr, sram_wmask and sram_wdata are don't-care when sram_en = 0; drive 0.
- Read latency: exactly 1. A read accepted in cycle N gives r_resp_valid = 1 in cycle N+1.
- Read data: in cycle N+1, r_resp_data = sram_rdata, and the hold register captures sram_rdata at the end of that cycle.
- Hold: in every cycle without a response, r_resp_data = hold register. A later write to the same address does not change the held data.
- Back-to-back reads: one read accepted per cycle gives one r_resp_valid pulse per cycle, in order.
- Read after write: a write in cycle N and a read of the same address in N+1 return the new data, with unmasked lanes keeping their old value. Same-cycle write and read: the write is performed, the read stalls (r_ready = 0).
- Reset mid-read: a pending response is dropped (r_resp_valid stays 0) and INIT restarts from address 0.
- Mask of all zeros: still a legal write cycle (sram_en = 1), no lanes change.

Test Plan:
- Reset, then idle DEPTH+2 cycles -> sram_en = 1 with wmode = 1 on addresses 0..255 in order, wmask = 0x3FF, wdata = 0; init_done rises at cycle 256; reads of addr 0, 0x80 and 0xFF return 0.
- Write addr 0x12, full mask, data = 0x5 in every lane; read 0x12 next cycle -> r_resp_valid one cycle after accept, data = 0x5 in each lane. Leave idle 5 cycles -> r_resp_data holds that value, r_resp_valid = 0.
- Write addr 0x12, mask = 0x001, lane0 = 0x3FFFFFFFF; read back -> lane0 = 0x3FFFFFFFF, lanes 1-9 still 0x5.
- w_valid and r_valid high together for 3 cycles -> r_ready = 0, three writes performed; read accepted in cycle 4, response in cycle 5.
- Reads to addresses 1, 2, 3 on consecutive cycles after writing 0x1/0x2/0x3 -> three consecutive r_resp_valid pulses carrying 0x1, 0x2, 0x3.
- Assert reset in the cycle after a read is accepted -> no r_resp_valid, init_done = 0 immediately, INIT restarts at address 0, and the array is zero again after 256 cycles.
